ts_proxy: RTL and testbench

TS_PROXY -- requirements
Module: ts_proxy

---
 rtl/ts_proxy_pkg.sv | 30 +++
 rtl/ts_proxy_if.sv | 22 ++
 rtl/ts_deser.sv | 73 +++++++
 rtl/ts_proxy.sv | 224 ++++++++++++++++++++++
 tb/tb_ts_proxy.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ts_proxy_pkg.sv
// Shared types and constants for the TS-to-USB proxy.
package ts_proxy_pkg;

    // Source select encodings.
    typedef enum logic [1:0] {
        INSEL_OFF  = 2'b00,
        INSEL_DVB  = 2'b01,
        INSEL_ATSC = 2'b10,
        INSEL_TEST = 2'b11
    } insel_e;

    // EP3 buffer writer states.
    typedef enum logic [1:0] {
        ST_WAIT_READY = 2'd0,
        ST_FILL       = 2'd1,
        ST_COMMIT     = 2'd2
    } wr_state_e;

    // One FIFO entry: assembled byte plus its packet-start flag.
    typedef struct packed {
        logic       start;
        logic [7:0] data;
    } fifo_entry_t;

    localparam int         FIFO_DEPTH = 16;
    localparam int         FIFO_AW    = 4;
    localparam logic [7:0] SYNC_BYTE  = 8'h47;
    localparam int         PKT_LEN    = 188;

endpackage

// File: rtl/ts_proxy_if.sv
// EP3 USB IN buffer port: byte writes plus commit handshake.
interface ts_proxy_if;
    logic [7:0]  ep3_usb_in_data;
    logic [10:0] ep3_usb_in_addr;
    logic        ep3_usb_in_wren;
    logic        ep3_usb_in_commit;
    logic [10:0] ep3_usb_in_commit_len;
    logic        ep3_usb_in_ready;
    logic        ep3_usb_in_commit_ack;

    modport master (
        output ep3_usb_in_data, ep3_usb_in_addr, ep3_usb_in_wren,
               ep3_usb_in_commit, ep3_usb_in_commit_len,
        input  ep3_usb_in_ready, ep3_usb_in_commit_ack
    );

    modport slave (
        input  ep3_usb_in_data, ep3_usb_in_addr, ep3_usb_in_wren,
               ep3_usb_in_commit, ep3_usb_in_commit_len,
        output ep3_usb_in_ready, ep3_usb_in_commit_ack
    );
endinterface

// File: rtl/ts_deser.sv
// Serial TS deserializer: synchronizes the source bit clock into clk,
// samples one bit per rising edge when valid, assembles MSB-first bytes.
module ts_deser (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       ts_clock,
    input  logic       ts_start,
    input  logic       ts_valid,
    input  logic       ts_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_start
);

    // [0],[1] form the 2-FF synchronizer; [2] is edge-detect history.
    logic [2:0] clk_sync;
    // Qualifiers ride the same two stages so they stay aligned with the clock.
    logic [1:0] start_sync;
    logic [1:0] valid_sync;
    logic [1:0] data_sync;
    logic [6:0] shreg;
    logic [2:0] bit_cnt;
    logic       pkt_flag;
    logic       sample;

    assign sample = clk_sync[1] & ~clk_sync[2] & valid_sync[1];

    // Synchronize inputs, shift in sampled bits, emit a byte on the 8th bit.
    // NOTE: sequential state uses non-blocking (<=) so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync   <= '0;
            start_sync <= '0;
            valid_sync <= '0;
            data_sync  <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            pkt_flag   <= 1'b0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_start <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[1:0], ts_clock};
            start_sync <= {start_sync[0], ts_start};
            valid_sync <= {valid_sync[0], ts_valid};
            data_sync  <= {data_sync[0], ts_data};
            byte_valid <= 1'b0;
            if (flush) begin
                shreg    <= '0;
                bit_cnt  <= '0;
                pkt_flag <= 1'b0;
            end else if (sample) begin
                if (start_sync[1]) begin
                    // Start bit is the MSB of a fresh, packet-start byte.
                    shreg    <= {6'b0, data_sync[1]};
                    bit_cnt  <= 3'd1;
                    pkt_flag <= 1'b1;
                end else if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shreg, data_sync[1]};
                    byte_start <= pkt_flag;
                    bit_cnt    <= 3'd0;
                    pkt_flag   <= 1'b0;
                end else begin
                    shreg   <= {shreg[5:0], data_sync[1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ts_proxy.sv
// TS proxy top: source mux, deserializer, test pattern generator,
// 16-entry byte FIFO with resync, and the EP3 buffer writer FSM.
module ts_proxy
    import ts_proxy_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        atsc_clock,
    input  logic        atsc_start,
    input  logic        atsc_valid,
    input  logic        atsc_data,
    input  logic        dvb_clock,
    input  logic        dvb_start,
    input  logic        dvb_valid,
    input  logic        dvb_data,
    input  logic [1:0]  insel,
    input  logic [10:0] commit_len,
    ts_proxy_if.master  ep3
);

    insel_e      sel;
    insel_e      sel_q;
    logic        sel_chg;

    logic        mux_clock, mux_start, mux_valid, mux_data;
    logic        des_valid, des_start;
    logic [7:0]  des_data;

    logic [1:0]  gen_div;
    logic [7:0]  gen_idx;
    logic [7:0]  gen_cnt;
    logic        gen_valid;

    logic        in_valid, in_start;
    logic [7:0]  in_data;

    fifo_entry_t mem [FIFO_DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, fifo_cnt;
    logic        fifo_full, fifo_empty, push, pop, resync;
    fifo_entry_t head;

    wr_state_e   state, state_next;
    logic [10:0] wr_cnt, len_q;
    logic        wren, commit;
    logic [7:0]  wr_data;
    logic [10:0] wr_addr, wr_commit_len;

    assign sel     = insel_e'(insel);
    assign sel_chg = (sel != sel_q);

    // Remember the previous select so a change can flush and resync.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sel_q <= INSEL_OFF;
        else          sel_q <= sel;
    end

    // Route the selected serial source into the single deserializer.
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        mux_clock = 1'b0;
        mux_start = 1'b0;
        mux_valid = 1'b0;
        mux_data  = 1'b0;
        case (sel)
            INSEL_DVB: begin
                mux_clock = dvb_clock;
                mux_start = dvb_start;
                mux_valid = dvb_valid;
                mux_data  = dvb_data;
            end
            INSEL_ATSC: begin
                mux_clock = atsc_clock;
                mux_start = atsc_start;
                mux_valid = atsc_valid;
                mux_data  = atsc_data;
            end
            default: ;
        endcase
    end

    ts_deser u_deser (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (sel_chg),
        .ts_clock   (mux_clock),
        .ts_start   (mux_start),
        .ts_valid   (mux_valid),
        .ts_data    (mux_data),
        .byte_valid (des_valid),
        .byte_data  (des_data),
        .byte_start (des_start)
    );

    // Test pattern: one byte per 4 clks, sync byte then 187 counter bytes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gen_div <= '0;
            gen_idx <= '0;
            gen_cnt <= '0;
        end else if (sel_chg || sel != INSEL_TEST) begin
            gen_div <= '0;
            gen_idx <= '0;
            gen_cnt <= '0;
        end else begin
            gen_div <= gen_div + 2'd1;
            if (gen_div == 2'd3) begin
                if (gen_idx == 8'(PKT_LEN - 1)) begin
                    gen_idx <= '0;
                    gen_cnt <= '0;
                end else begin
                    gen_idx <= gen_idx + 8'd1;
                    if (gen_idx != 8'd0) gen_cnt <= gen_cnt + 8'd1;
                end
            end
        end
    end

    assign gen_valid = (sel == INSEL_TEST) && (gen_div == 2'd3);

    // Pick the byte stream feeding the FIFO; nothing passes on a select change.
    always_comb begin
        in_valid = 1'b0;
        in_start = 1'b0;
        in_data  = '0;
        case (sel)
            INSEL_DVB, INSEL_ATSC: begin
                in_valid = des_valid;
                in_start = des_start;
                in_data  = des_data;
            end
            INSEL_TEST: begin
                in_valid = gen_valid;
                in_start = (gen_idx == 8'd0);
                in_data  = (gen_idx == 8'd0) ? SYNC_BYTE : gen_cnt;
            end
            default: ;
        endcase
        if (sel_chg) in_valid = 1'b0;
    end

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_cnt == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign push       = in_valid && !fifo_full && (!resync || in_start);
    assign head       = mem[rd_ptr[FIFO_AW-1:0]];

    // FIFO pointers and resync: drop bytes until a start byte, resync on overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            resync <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + (FIFO_AW + 1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (FIFO_AW + 1)'(1);
            if (sel_chg)                   resync <= 1'b1;
            else if (in_valid && fifo_full) resync <= 1'b1;
            else if (push)                  resync <= 1'b0;
        end
    end

    // FIFO storage write.
    // NOTE: storage has no reset; emptiness is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[FIFO_AW-1:0]] <= '{start: in_start, data: in_data};
    end

    // Writer state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_WAIT_READY;
        else          state <= state_next;
    end

    // Writer next-state and EP3 outputs.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        wren          = 1'b0;
        commit        = 1'b0;
        wr_data       = '0;
        wr_addr       = '0;
        wr_commit_len = '0;
        case (state)
            ST_WAIT_READY: begin
                if (ep3.ep3_usb_in_ready) state_next = ST_FILL;
            end
            ST_FILL: begin
                wr_addr = wr_cnt;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    wren    = 1'b1;
                    wr_data = head.data;
                    if (wr_cnt == len_q - 11'd1) state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit        = 1'b1;
                wr_commit_len = len_q;
                if (ep3.ep3_usb_in_commit_ack) state_next = ST_WAIT_READY;
            end
            default: state_next = ST_WAIT_READY;
        endcase
    end

    // Latch buffer length on FILL entry and count bytes written into it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt <= '0;
            len_q  <= '0;
        end else if (state == ST_WAIT_READY && ep3.ep3_usb_in_ready) begin
            wr_cnt <= '0;
            len_q  <= (commit_len == 11'd0) ? 11'd1 : commit_len;
        end else if (pop) begin
            wr_cnt <= wr_cnt + 11'd1;
        end
    end

    assign ep3.ep3_usb_in_data       = wr_data;
    assign ep3.ep3_usb_in_addr       = wr_addr;
    assign ep3.ep3_usb_in_wren       = wren;
    assign ep3.ep3_usb_in_commit     = commit;
    assign ep3.ep3_usb_in_commit_len = wr_commit_len;

endmodule

// File: tb/tb_ts_proxy.sv
// Scoreboard bench for ts_proxy: stimulus pushes expected writes/commits,
// a negedge monitor pops and compares them and answers commits with an ack.
module tb_ts_proxy;
    import ts_proxy_pkg::*;

    localparam int ACK_DELAY = 3;

    typedef struct {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        atsc_clock = 1'b0, atsc_start = 1'b0, atsc_valid = 1'b0, atsc_data = 1'b0;
    logic        dvb_clock = 1'b0, dvb_start = 1'b0, dvb_valid = 1'b0, dvb_data = 1'b0;
    logic [1:0]  insel = 2'b00;
    logic [10:0] commit_len = 11'd0;

    ts_proxy_if ep3_if ();

    int n_checks = 0;
    int n_fail = 0;
    int commit_done = 0;
    int commit_hi = 0;
    logic commit_q = 1'b0;
    logic prev_wren = 1'b0;

    wr_t exp_wr[$];
    int  exp_commit[$];

    always #5 clk = ~clk;

    ts_proxy dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .atsc_clock (atsc_clock),
        .atsc_start (atsc_start),
        .atsc_valid (atsc_valid),
        .atsc_data  (atsc_data),
        .dvb_clock  (dvb_clock),
        .dvb_start  (dvb_start),
        .dvb_valid  (dvb_valid),
        .dvb_data   (dvb_data),
        .insel      (insel),
        .commit_len (commit_len),
        .ep3        (ep3_if)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_write(input int a, input logic [7:0] d);
        wr_t e;
        e.addr = 11'(a);
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic drive(input bit use_dvb, input logic c, input logic s, input logic v, input logic d);
        if (use_dvb) begin
            dvb_clock = c; dvb_start = s; dvb_valid = v; dvb_data = d;
        end else begin
            atsc_clock = c; atsc_start = s; atsc_valid = v; atsc_data = d;
        end
    endtask

    // One bit per 3 clks (low, low, high); start flag only on the MSB.
    task automatic send_byte(input bit use_dvb, input logic [7:0] b, input bit st);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            drive(use_dvb, 1'b0, st && (i == 7), 1'b1, b[i]);
            @(negedge clk);
            @(negedge clk);
            drive(use_dvb, 1'b1, st && (i == 7), 1'b1, b[i]);
        end
        @(negedge clk);
        drive(use_dvb, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input logic [1:0] s, input logic [10:0] len, input logic rdy);
        @(negedge clk);
        insel = s;
        commit_len = len;
        ep3_if.ep3_usb_in_ready = rdy;
        reset_n = 1'b0;
        #1;
        check("rst_data",   32'(ep3_if.ep3_usb_in_data), 0);
        check("rst_addr",   32'(ep3_if.ep3_usb_in_addr), 0);
        check("rst_wren",   32'(ep3_if.ep3_usb_in_wren), 0);
        check("rst_commit", 32'(ep3_if.ep3_usb_in_commit), 0);
        check("rst_clen",   32'(ep3_if.ep3_usb_in_commit_len), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            #1;
            done = (exp_wr.size() == 0) && (exp_commit.size() == 0) && !ep3_if.ep3_usb_in_commit;
        end
        check("idle_timeout", 32'(done), 1);
    endtask

    task automatic wait_commits(input int n, input int max_cycles);
        for (int i = 0; i < max_cycles && commit_done < n; i++) @(negedge clk);
        check("commit_wait_timeout", 32'(commit_done), 32'(n));
    endtask

    // Monitor: compare writes/commits against the scoreboard and ack commits.
    always @(negedge clk) begin
        wr_t e;
        int  l;
        if (ep3_if.ep3_usb_in_wren) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_wren", 32'(ep3_if.ep3_usb_in_wren), 0);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(ep3_if.ep3_usb_in_addr), 32'(e.addr));
                check("wr_data", 32'(ep3_if.ep3_usb_in_data), 32'(e.data));
            end
        end
        if (ep3_if.ep3_usb_in_commit && !commit_q) begin
            if (exp_commit.size() == 0) begin
                check("unexpected_commit", 32'(ep3_if.ep3_usb_in_commit), 0);
            end else begin
                l = exp_commit.pop_front();
                check("commit_len", 32'(ep3_if.ep3_usb_in_commit_len), 32'(l));
                check("commit_after_wren", 32'(prev_wren), 1);
            end
        end
        if (!ep3_if.ep3_usb_in_commit && commit_q) begin
            check("commit_hold", 32'(commit_hi), 32'(ACK_DELAY));
            commit_done++;
        end
        if (ep3_if.ep3_usb_in_commit) begin
            commit_hi++;
            ep3_if.ep3_usb_in_commit_ack = (commit_hi == ACK_DELAY);
        end else begin
            commit_hi = 0;
            ep3_if.ep3_usb_in_commit_ack = 1'b0;
        end
        commit_q  = ep3_if.ep3_usb_in_commit;
        prev_wren = ep3_if.ep3_usb_in_wren;
    end

    initial begin
        #950000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ep3_if.ep3_usb_in_ready = 1'b0;
        ep3_if.ep3_usb_in_commit_ack = 1'b0;

        // ATSC: pre-start bytes dropped, then 47,55,AA... into a 1020-byte buffer.
        do_reset(2'b10, 11'd1020, 1'b1);
        send_byte(0, 8'h12, 0);
        send_byte(0, 8'h34, 0);
        send_byte(0, 8'h56, 0);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 1020; i++)
            exp_write(i, (i == 0) ? 8'h47 : (i == 1) ? 8'h55 : 8'hAA);
        exp_commit.push_back(1020);
        send_byte(0, 8'h47, 1);
        send_byte(0, 8'h55, 0);
        commit_len = 11'd5;
        for (int i = 2; i < 1020; i++) send_byte(0, 8'hAA, 0);
        wait_idle(200);

        // ready=0: FIFO fills with 47,01..0F, overflow drops and resyncs.
        do_reset(2'b10, 11'd4, 1'b0);
        send_byte(0, 8'h47, 1);
        for (int i = 1; i <= 30; i++) send_byte(0, 8'(i), 0);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 16; i++) exp_write(i % 4, (i == 0) ? 8'h47 : 8'(i));
        for (int i = 0; i < 4; i++) exp_commit.push_back(4);
        ep3_if.ep3_usb_in_ready = 1'b1;
        wait_idle(300);
        send_byte(0, 8'hC0, 0);
        send_byte(0, 8'hC1, 0);
        exp_write(0, 8'h47); exp_write(1, 8'hB0); exp_write(2, 8'hB1); exp_write(3, 8'hB2);
        exp_commit.push_back(4);
        send_byte(0, 8'h47, 1);
        send_byte(0, 8'hB0, 0);
        send_byte(0, 8'hB1, 0);
        send_byte(0, 8'hB2, 0);
        wait_idle(200);

        // DVB selected: ATSC activity ignored, DVB stream written.
        do_reset(2'b01, 11'd8, 1'b1);
        send_byte(0, 8'h47, 1);
        send_byte(0, 8'h11, 0);
        send_byte(0, 8'h22, 0);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 8; i++)
            exp_write(i, (i == 0) ? 8'h47 : (i == 1) ? 8'h55 : 8'hAA);
        exp_commit.push_back(8);
        send_byte(1, 8'h47, 1);
        send_byte(1, 8'h55, 0);
        for (int i = 2; i < 8; i++) send_byte(1, 8'hAA, 0);
        wait_idle(200);

        // 500 bytes, then reset mid-buffer: no commit, next buffer restarts at 0.
        do_reset(2'b10, 11'd1020, 1'b1);
        for (int i = 0; i < 500; i++) exp_write(i, (i == 0) ? 8'h47 : 8'(i));
        send_byte(0, 8'h47, 1);
        for (int i = 1; i < 500; i++) send_byte(0, 8'(i), 0);
        wait_idle(200);
        repeat (5) @(negedge clk);
        do_reset(2'b10, 11'd4, 1'b1);
        exp_write(0, 8'h47); exp_write(1, 8'h01); exp_write(2, 8'h02); exp_write(3, 8'h03);
        exp_commit.push_back(4);
        send_byte(0, 8'h47, 1);
        send_byte(0, 8'h01, 0);
        send_byte(0, 8'h02, 0);
        send_byte(0, 8'h03, 0);
        wait_idle(200);

        // Test pattern, 4-byte buffers; ready drops during FILL without stalling.
        do_reset(2'b11, 11'd4, 1'b0);
        commit_done = 0;
        exp_write(0, 8'h47); exp_write(1, 8'h00); exp_write(2, 8'h01); exp_write(3, 8'h02);
        exp_commit.push_back(4);
        ep3_if.ep3_usb_in_ready = 1'b1;
        @(negedge clk);
        ep3_if.ep3_usb_in_ready = 1'b0;
        wait_commits(1, 200);
        exp_write(0, 8'h03); exp_write(1, 8'h04); exp_write(2, 8'h05); exp_write(3, 8'h06);
        exp_commit.push_back(4);
        ep3_if.ep3_usb_in_ready = 1'b1;
        @(negedge clk);
        ep3_if.ep3_usb_in_ready = 1'b0;
        wait_commits(2, 200);
        insel = 2'b00;
        repeat (20) @(negedge clk);
        wait_idle(50);

        // commit_len=0 behaves as a single-byte buffer.
        do_reset(2'b11, 11'd0, 1'b0);
        exp_write(0, 8'h47);
        exp_commit.push_back(1);
        ep3_if.ep3_usb_in_ready = 1'b1;
        @(negedge clk);
        ep3_if.ep3_usb_in_ready = 1'b0;
        wait_idle(200);
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
